mem_port_arbiter: RTL and testbench

Shares one single-port memory between the instruction-fetch port and the load/store data port of the CPU core. It uses a req/ack handshake and fixed-priority arbitration with a starvation guard, and drives the memory through registered outputs with a fixed read latency. It also keeps per-port wait-cycle counters that the performance-metric logic reads.

---
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store data,
// with a fixed-priority grant, a fetch starvation guard and per-port wait counters.
module mem_port_arbiter #(
   parameter int unsigned MEM_LATENCY = 1,
   parameter int unsigned MAX_STREAK  = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ack,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy,
   output logic [31:0] if_wait_cycles,
   output logic [31:0] d_wait_cycles
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam logic [2:0] LAT_LOAD   = 3'(MEM_LATENCY);
   localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

   state_t      state, state_nx;
   logic        owner_d, owner_d_nx;
   logic [2:0]  lat_cnt, lat_cnt_nx;
   logic [3:0]  streak, streak_nx;
   logic        mem_en_nx, mem_we_nx, if_ack_nx, d_ack_nx;
   logic [31:0] mem_addr_nx, mem_wdata_nx, if_rdata_nx, d_rdata_nx;
   logic [31:0] if_wait_q, d_wait_q;
   logic        grant_d;

   // Data wins a contended grant unless fetch has already lost MAX_STREAK in a row.
   assign grant_d = d_req && !(if_req && streak == STREAK_MAX);

   assign busy           = (state != IDLE);
   assign if_wait_cycles = if_wait_q;
   assign d_wait_cycles  = d_wait_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         owner_d   <= 1'b0;
         lat_cnt   <= '0;
         streak    <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_ack    <= 1'b0;
         d_ack     <= 1'b0;
         if_rdata  <= '0;
         d_rdata   <= '0;
      end else begin
         state     <= state_nx;
         owner_d   <= owner_d_nx;
         lat_cnt   <= lat_cnt_nx;
         streak    <= streak_nx;
         mem_en    <= mem_en_nx;
         mem_we    <= mem_we_nx;
         mem_addr  <= mem_addr_nx;
         mem_wdata <= mem_wdata_nx;
         if_ack    <= if_ack_nx;
         d_ack     <= d_ack_nx;
         if_rdata  <= if_rdata_nx;
         d_rdata   <= d_rdata_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      owner_d_nx   = owner_d;
      lat_cnt_nx   = lat_cnt;
      streak_nx    = streak;
      mem_en_nx    = 1'b0;
      mem_we_nx    = mem_we;
      mem_addr_nx  = mem_addr;
      mem_wdata_nx = mem_wdata;
      if_ack_nx    = 1'b0;
      d_ack_nx     = 1'b0;
      if_rdata_nx  = if_rdata;
      d_rdata_nx   = d_rdata;
      case (state)
         IDLE: begin
            if (if_req || d_req) begin
               owner_d_nx  = grant_d;
               mem_en_nx   = 1'b1;
               mem_we_nx   = grant_d && d_we;
               mem_addr_nx = grant_d ? d_addr : if_addr;
               if (grant_d) begin
                  mem_wdata_nx = d_wdata;
               end
               // A contended data grant can only happen below the limit, so the streak stays bounded.
               streak_nx   = (grant_d && if_req) ? streak + 4'd1 : 4'd0;
               lat_cnt_nx  = LAT_LOAD;
               state_nx    = WAIT;
            end
         end
         WAIT: begin
            if (lat_cnt == 3'd0) begin
               if (owner_d) begin
                  d_ack_nx = 1'b1;
                  if (!mem_we) begin
                     d_rdata_nx = mem_rdata;
                  end
               end else begin
                  if_ack_nx   = 1'b1;
                  if_rdata_nx = mem_rdata;
               end
               state_nx = RESP;
            end else begin
               lat_cnt_nx = lat_cnt - 3'd1;
            end
         end
         RESP: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Wait counters run in every state and stick at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         if_wait_q <= '0;
         d_wait_q  <= '0;
      end else begin
         if (if_req && !if_ack && if_wait_q != 32'hFFFF_FFFF) begin
            if_wait_q <= if_wait_q + 32'd1;
         end
         if (d_req && !d_ack && d_wait_q != 32'hFFFF_FFFF) begin
            d_wait_q <= d_wait_q + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table plus hand-timed sequences, read data
// checked through per-port scoreboards against a bench-side memory model.
module tb_mem_port_arbiter;

   localparam int LAT = 1;
   localparam int MAXS = 3;

   logic        clk;
   logic        reset;
   logic        if_req, if_ack, d_req, d_we, d_ack;
   logic        mem_en, mem_we, busy;
   logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [31:0] if_wait_cycles, d_wait_cycles;

   mem_port_arbiter #(.MEM_LATENCY(LAT), .MAX_STREAK(MAXS)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy),
      .if_wait_cycles(if_wait_cycles), .d_wait_cycles(d_wait_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] init_val(input logic [7:0] a);
      case (a)
         8'h10:   return 32'hDEAD_BEEF;
         8'h84:   return 32'h5555_5555;
         default: return {8'h3C, a, ~a, a};
      endcase
   endfunction

   // Memory with a one-cycle read latency: data appears in the cycle after mem_en is sampled.
   logic [31:0] tmem [256];
   bit          tvld [256];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            tmem[mem_addr[7:0]] <= mem_wdata;
            tvld[mem_addr[7:0]] <= 1'b1;
         end
         mem_rdata <= tvld[mem_addr[7:0]] ? tmem[mem_addr[7:0]] : init_val(mem_addr[7:0]);
      end
   end

   typedef struct {
      bit          we;
      logic [31:0] exp;
   } d_exp_t;

   typedef struct {
      bit          use_if;
      bit          use_d;
      bit          d_we;
      logic [31:0] if_addr;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      string       exp_order;
      int          exp_gap;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          if_ack_cyc, d_ack_cyc;
   string       ack_order;
   logic [31:0] if_q [$];
   d_exp_t      d_q [$];
   logic [31:0] d_last;
   logic [31:0] ref_mem [256];
   bit          ref_vld [256];
   vec_t        vecs [7];

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      return ref_vld[a[7:0]] ? ref_mem[a[7:0]] : init_val(a[7:0]);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_order(input string name, input string act, input string exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got '%s' expected '%s'", name, act, exp);
      end
   endtask

   // Wait for the given ack at negedges with a cycle budget; returns 0 on timeout.
   task automatic wait_ack(input bit data_port, output bit ok);
      ok = 1'b0;
      for (int t = 0; t < 60; t++) begin
         @(negedge clk);
         if (data_port ? d_ack : if_ack) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s_ack_timeout: got no ack expected ack within 60 cycles",
                  data_port ? "d" : "if");
      end
   endtask

   task automatic fetchSeq(input int n, input logic [31:0] base);
      bit ok;
      @(negedge clk);
      for (int i = 0; i < n; i++) begin
         if_req  = 1'b1;
         if_addr = base + 32'(4 * i);
         if_q.push_back(ref_read(if_addr));
         wait_ack(1'b0, ok);
         if (!ok) break;
      end
      if_req = 1'b0;
   endtask

   task automatic dataSeq(input int n, input bit we, input logic [31:0] base, input logic [31:0] wdata);
      bit     ok;
      d_exp_t e;
      @(negedge clk);
      for (int i = 0; i < n; i++) begin
         d_req   = 1'b1;
         d_we    = we;
         d_addr  = base + 32'(4 * i);
         d_wdata = wdata + 32'(i);
         e.we    = we;
         e.exp   = we ? 32'h0 : ref_read(d_addr);
         if (we) begin
            ref_mem[d_addr[7:0]] = d_wdata;
            ref_vld[d_addr[7:0]] = 1'b1;
         end
         d_q.push_back(e);
         wait_ack(1'b1, ok);
         if (!ok) break;
      end
      d_req = 1'b0;
   endtask

   task automatic applyStimulus(input vec_t v);
      ack_order = "";
      fork
         if (v.use_if) fetchSeq(1, v.if_addr);
         if (v.use_d) dataSeq(1, v.d_we, v.d_addr, v.d_wdata);
      join
      @(negedge clk);
      check_order("ack_order", ack_order, v.exp_order);
      if (v.exp_gap > 0) begin
         checkOutput("grant_gap", 32'(if_ack_cyc - d_ack_cyc), 32'(v.exp_gap));
      end
   endtask

   initial begin
      d_exp_t e;
      logic [31:0] ie;
      reset = 1'b0;
      if_req = 1'b0; if_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      d_last = '0;

      vecs[0] = '{1, 1, 0, 32'h44, 32'h40, 32'h0,          "DF", LAT + 3};
      vecs[1] = '{1, 0, 0, 32'h30, 32'h0,  32'h0,          "F",  0};
      vecs[2] = '{0, 1, 0, 32'h0,  32'h80, 32'h0,          "D",  0};
      vecs[3] = '{1, 1, 1, 32'h34, 32'h90, 32'hCAFE_0001,  "DF", LAT + 3};
      vecs[4] = '{0, 1, 0, 32'h0,  32'h90, 32'h0,          "D",  0};
      vecs[5] = '{1, 1, 0, 32'hFC, 32'h00, 32'h0,          "DF", LAT + 3};
      vecs[6] = '{1, 1, 1, 32'h50, 32'h54, 32'hFFFF_0000,  "DF", LAT + 3};

      fork
         forever @(posedge clk) cyc++;
         // Scoreboard: every ack pops the oldest expected result for its port.
         forever begin
            @(negedge clk);
            if (reset && if_ack) begin
               ack_order  = {ack_order, "F"};
               if_ack_cyc = cyc;
               if (if_q.size() == 0) begin
                  checks++; errors++;
                  $display("[TB] FAIL if_ack_unexpected: got ack expected none");
               end else begin
                  ie = if_q.pop_front();
                  checkOutput("if_rdata", if_rdata, ie);
               end
            end
            if (reset && d_ack) begin
               ack_order = {ack_order, "D"};
               d_ack_cyc = cyc;
               if (d_q.size() == 0) begin
                  checks++; errors++;
                  $display("[TB] FAIL d_ack_unexpected: got ack expected none");
               end else begin
                  e = d_q.pop_front();
                  if (!e.we) d_last = e.exp;
                  checkOutput("d_rdata", d_rdata, d_last);
               end
            end
         end
         begin
            #200000;
            $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
            $fatal(1, "[TB] watchdog expired");
         end
      join_none

      // Reset values.
      repeat (3) @(negedge clk);
      checkOutput("rst_mem_en", {31'b0, mem_en}, 32'h0);
      checkOutput("rst_if_ack", {31'b0, if_ack}, 32'h0);
      checkOutput("rst_d_ack", {31'b0, d_ack}, 32'h0);
      checkOutput("rst_busy", {31'b0, busy}, 32'h0);
      checkOutput("rst_mem_addr", mem_addr, 32'h0);
      checkOutput("rst_if_rdata", if_rdata, 32'h0);
      checkOutput("rst_d_rdata", d_rdata, 32'h0);
      checkOutput("rst_if_wait", if_wait_cycles, 32'h0);
      checkOutput("rst_d_wait", d_wait_cycles, 32'h0);
      reset = 1'b1;

      // Lone fetch with exact cycle timing around grant edge G.
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h10;
      if_q.push_back(ref_read(32'h10));
      @(posedge clk); #1;
      checkOutput("lf_mem_en_G", {31'b0, mem_en}, 32'h1);
      checkOutput("lf_mem_addr", mem_addr, 32'h10);
      checkOutput("lf_mem_we", {31'b0, mem_we}, 32'h0);
      checkOutput("lf_busy", {31'b0, busy}, 32'h1);
      @(posedge clk); #1;
      checkOutput("lf_mem_en_G1", {31'b0, mem_en}, 32'h0);
      checkOutput("lf_if_ack_G1", {31'b0, if_ack}, 32'h0);
      @(posedge clk); #1;
      checkOutput("lf_if_ack_G2", {31'b0, if_ack}, 32'h1);
      checkOutput("lf_if_rdata", if_rdata, 32'hDEAD_BEEF);
      if_req = 1'b0;
      @(posedge clk); #1;
      checkOutput("lf_if_ack_G3", {31'b0, if_ack}, 32'h0);
      checkOutput("lf_busy_G3", {31'b0, busy}, 32'h0);
      checkOutput("lf_if_wait", if_wait_cycles, 32'd3);
      checkOutput("lf_d_wait", d_wait_cycles, 32'd0);

      // Store leaves d_rdata at the previous load value.
      dataSeq(1, 1'b0, 32'h84, 32'h0);
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h0000_1234;
      ref_mem[8'h80] = 32'h0000_1234; ref_vld[8'h80] = 1'b1;
      e.we = 1'b1; e.exp = 32'h0;
      d_q.push_back(e);
      @(posedge clk); #1;
      checkOutput("st_mem_en", {31'b0, mem_en}, 32'h1);
      checkOutput("st_mem_we", {31'b0, mem_we}, 32'h1);
      checkOutput("st_mem_addr", mem_addr, 32'h80);
      checkOutput("st_mem_wdata", mem_wdata, 32'h0000_1234);
      @(posedge clk); #1;
      checkOutput("st_d_ack_G1", {31'b0, d_ack}, 32'h0);
      @(posedge clk); #1;
      checkOutput("st_d_ack_G2", {31'b0, d_ack}, 32'h1);
      checkOutput("st_d_rdata", d_rdata, 32'h5555_5555);
      d_req = 1'b0; d_we = 1'b0;
      @(posedge clk); #1;

      // Table-driven vectors.
      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i]);
      end

      // Reset during WAIT abandons the access.
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h88;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      d_last = '0;
      checkOutput("mid_rst_mem_en", {31'b0, mem_en}, 32'h0);
      checkOutput("mid_rst_d_ack", {31'b0, d_ack}, 32'h0);
      checkOutput("mid_rst_busy", {31'b0, busy}, 32'h0);
      checkOutput("mid_rst_if_wait", if_wait_cycles, 32'h0);
      checkOutput("mid_rst_d_wait", d_wait_cycles, 32'h0);
      checkOutput("mid_rst_d_rdata", d_rdata, 32'h0);
      d_req = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (6) @(negedge clk);
      applyStimulus('{0, 1, 0, 32'h0, 32'h88, 32'h0, "D", 0});

      // Starvation guard: both ports hammer continuously.
      ack_order = "";
      fork
         fetchSeq(2, 32'h20);
         dataSeq(6, 1'b0, 32'h60, 32'h0);
      join
      @(negedge clk);
      check_order("starve_order", ack_order, "DDDFDDDF");

      // Wait counter saturation while fetch is starved.
      fork
         fetchSeq(1, 32'h2C);
         dataSeq(3, 1'b0, 32'h70, 32'h0);
         begin
            @(negedge clk);
            @(negedge clk);
            force dut.if_wait_q = 32'hFFFF_FFFE;
            #1;
            release dut.if_wait_q;
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               checkOutput("if_wait_sat", if_wait_cycles, 32'hFFFF_FFFF);
            end
         end
      join
      @(negedge clk);
      checkOutput("if_wait_sat_end", if_wait_cycles, 32'hFFFF_FFFF);
      checkOutput("if_q_drained", 32'(if_q.size()), 32'd0);
      checkOutput("d_q_drained", 32'(d_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
